// File: rtl/i2c_wb_cmd_sequencer_pkg.sv
// Shared types for the IICMB command sequencer:
// CMDR command codes, register map, status bits, FSM states and steps.
package i2c_wb_cmd_sequencer_pkg;

    typedef enum logic [7:0] {
        CMD_WAIT   = 8'h00,
        CMD_WRITE  = 8'h01,
        CMD_RWACK  = 8'h02,
        CMD_RWNACK = 8'h03,
        CMD_START  = 8'h04,
        CMD_STOP   = 8'h05,
        CMD_SETBUS = 8'h06
    } cmdr_cmd_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } i2c_op_t;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;
    localparam logic [1:0] REG_FSMR = 2'd3;

    localparam int CSR_E_BIT    = 7;
    localparam int CSR_IE_BIT   = 6;
    localparam int CMDR_DON_BIT = 7;
    localparam int CMDR_NAK_BIT = 6;
    localparam int CMDR_AL_BIT  = 5;
    localparam int CMDR_ERR_BIT = 4;

    localparam logic [7:0] CSR_ENABLE =
        (8'd1 << CSR_E_BIT) | (8'd1 << CSR_IE_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_WRITE,
        S_WB_READ,
        S_WAIT_IRQ,
        S_EVAL,
        S_RESP
    } seq_state_t;

    typedef enum logic [3:0] {
        STEP_CSR,
        STEP_BUS_DPR,
        STEP_BUS_CMD,
        STEP_START_CMD,
        STEP_ADDR_DPR,
        STEP_ADDR_CMD,
        STEP_WDATA_DPR,
        STEP_WDATA_CMD,
        STEP_RDATA_CMD,
        STEP_RDATA_RD,
        STEP_STOP_CMD
    } seq_step_t;

    // Normal (no NAK/failure) successor of a step.
    function automatic seq_step_t next_step(seq_step_t s, i2c_op_t op);
        seq_step_t n;
        n = STEP_STOP_CMD;
        unique case (s)
            STEP_CSR:       n = STEP_BUS_DPR;
            STEP_BUS_DPR:   n = STEP_BUS_CMD;
            STEP_BUS_CMD:   n = STEP_START_CMD;
            STEP_START_CMD: n = STEP_ADDR_DPR;
            STEP_ADDR_DPR:  n = STEP_ADDR_CMD;
            STEP_ADDR_CMD:  n = (op == OP_READ) ? STEP_RDATA_CMD
                                                : STEP_WDATA_DPR;
            STEP_WDATA_DPR: n = STEP_WDATA_CMD;
            STEP_WDATA_CMD: n = STEP_STOP_CMD;
            STEP_RDATA_CMD: n = STEP_RDATA_RD;
            STEP_RDATA_RD:  n = STEP_STOP_CMD;
            default:        n = STEP_STOP_CMD;
        endcase
        return n;
    endfunction

    // Steps that write CMDR and therefore wait for irq + status.
    function automatic logic is_cmd_step(seq_step_t s);
        return (s == STEP_BUS_CMD)   || (s == STEP_START_CMD) ||
               (s == STEP_ADDR_CMD)  || (s == STEP_WDATA_CMD) ||
               (s == STEP_RDATA_CMD) || (s == STEP_STOP_CMD);
    endfunction

endpackage

// File: rtl/i2c_wb_cmd_sequencer_port.sv
// Single-access classic Wishbone master port.
// Bus controls are registered and held until ack; done is the ack cycle.
module i2c_wb_master_port #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     we_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic                     done_o,
    output logic [WB_DATA_WIDTH-1:0] rdata_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic                     wb_ack_i
);

    // Launch on start while idle, drop everything the cycle after ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else if (wb_cyc_o && wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else if (start_i && !wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= we_i;
            wb_adr_o <= adr_i;
            wb_dat_o <= dat_i;
        end
    end

    assign done_o  = wb_cyc_o & wb_ack_i;
    assign rdata_o = wb_dat_i;

endmodule

// File: rtl/i2c_wb_cmd_sequencer.sv
// Wishbone master driving IICMB through one single-byte I2C transfer:
// enable, set bus, start, address, data, stop; returns byte and status.
module i2c_wb_cmd_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int BUS_ID_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [BUS_ID_WIDTH-1:0]   req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_op_i,
    input  logic [WB_DATA_WIDTH-1:0]  req_data_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [WB_DATA_WIDTH-1:0]  rsp_data_o,
    output logic                      rsp_nack_o,
    output logic                      rsp_err_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0]  wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0]  wb_dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      irq_i
);

    import i2c_wb_cmd_sequencer_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(REG_CSR);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(REG_DPR);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(REG_CMDR);

    seq_state_t                state_q;
    seq_state_t                state_d;
    seq_step_t                 step_q;
    seq_step_t                 step_nx;
    logic                      enabled_q;
    logic [BUS_ID_WIDTH-1:0]   bus_q;
    logic [I2C_ADDR_WIDTH-1:0] addr_q;
    i2c_op_t                   op_q;
    logic [WB_DATA_WIDTH-1:0]  wdata_q;
    logic [WB_DATA_WIDTH-1:0]  rdata_q;
    logic                      nack_q;
    logic                      err_q;
    logic                      st_nak_q;
    logic                      st_fail_q;
    logic [CNT_W-1:0]          cnt_q;

    logic                      accept;
    logic                      timeout;
    logic                      cmd_step;
    logic                      data_step;
    logic                      rd_fail;
    logic [WB_ADDR_WIDTH-1:0]  wr_adr;
    logic [WB_DATA_WIDTH-1:0]  wr_dat;

    logic                      port_start;
    logic                      port_we;
    logic [WB_ADDR_WIDTH-1:0]  port_adr;
    logic [WB_DATA_WIDTH-1:0]  port_dat;
    logic                      port_done;
    logic [WB_DATA_WIDTH-1:0]  port_rdata;

    assign accept    = req_valid_i && (state_q == S_IDLE);
    assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign step_nx   = next_step(step_q, op_q);
    assign cmd_step  = is_cmd_step(step_q);
    assign data_step = (step_q == STEP_ADDR_CMD)  ||
                       (step_q == STEP_WDATA_CMD) ||
                       (step_q == STEP_RDATA_CMD);
    assign rd_fail   = port_rdata[CMDR_AL_BIT] | port_rdata[CMDR_ERR_BIT];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection; EVAL routes on the captured CMDR status.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_WB_WRITE;
            end
            S_WB_WRITE: begin
                if (port_done && cmd_step) state_d = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (irq_i)        state_d = S_WB_READ;
                else if (timeout) state_d = S_RESP;
            end
            S_WB_READ: begin
                if (port_done) begin
                    if (step_q == STEP_RDATA_RD)      state_d = S_WB_WRITE;
                    else if (step_q == STEP_STOP_CMD) state_d = S_RESP;
                    else                              state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (st_fail_q)                   state_d = S_RESP;
                else if (st_nak_q && data_step)  state_d = S_WB_WRITE;
                else if (step_nx == STEP_RDATA_RD) state_d = S_WB_READ;
                else                             state_d = S_WB_WRITE;
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and port requests decoded from the state.
    always_comb begin
        req_ready_o = (state_q == S_IDLE) && !rst_i;
        rsp_valid_o = (state_q == S_RESP);
        rsp_err_o   = rsp_valid_o && err_q;
        rsp_nack_o  = rsp_valid_o && nack_q && !err_q;
        rsp_data_o  = (rsp_valid_o && !err_q && !nack_q) ? rdata_q : '0;
        port_start  = 1'b0;
        port_we     = 1'b0;
        port_adr    = '0;
        port_dat    = '0;
        unique case (state_q)
            S_WB_WRITE: begin
                port_start = 1'b1;
                port_we    = 1'b1;
                port_adr   = wr_adr;
                port_dat   = wr_dat;
            end
            S_WB_READ: begin
                port_start = 1'b1;
                port_adr   = (step_q == STEP_RDATA_RD) ? ADR_DPR : ADR_CMDR;
            end
            default: ;
        endcase
    end

    // Register and value written for the current step.
    always_comb begin
        wr_adr = ADR_CMDR;
        wr_dat = '0;
        unique case (step_q)
            STEP_CSR: begin
                wr_adr = ADR_CSR;
                wr_dat = WB_DATA_WIDTH'(CSR_ENABLE);
            end
            STEP_BUS_DPR: begin
                wr_adr = ADR_DPR;
                wr_dat = WB_DATA_WIDTH'(bus_q);
            end
            STEP_BUS_CMD:   wr_dat = WB_DATA_WIDTH'(CMD_SETBUS);
            STEP_START_CMD: wr_dat = WB_DATA_WIDTH'(CMD_START);
            STEP_ADDR_DPR: begin
                wr_adr = ADR_DPR;
                wr_dat = WB_DATA_WIDTH'({addr_q, op_q});
            end
            STEP_ADDR_CMD:  wr_dat = WB_DATA_WIDTH'(CMD_WRITE);
            STEP_WDATA_DPR: begin
                wr_adr = ADR_DPR;
                wr_dat = wdata_q;
            end
            STEP_WDATA_CMD: wr_dat = WB_DATA_WIDTH'(CMD_WRITE);
            STEP_RDATA_CMD: wr_dat = WB_DATA_WIDTH'(CMD_RWNACK);
            STEP_STOP_CMD:  wr_dat = WB_DATA_WIDTH'(CMD_STOP);
            default: ;
        endcase
    end

    // Request latch, step index, enable flag and response flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q    <= STEP_CSR;
            enabled_q <= 1'b0;
            bus_q     <= '0;
            addr_q    <= '0;
            op_q      <= OP_WRITE;
            wdata_q   <= '0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            err_q     <= 1'b0;
            st_nak_q  <= 1'b0;
            st_fail_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        bus_q   <= req_bus_i;
                        addr_q  <= req_addr_i;
                        op_q    <= i2c_op_t'(req_op_i);
                        wdata_q <= req_data_i;
                        rdata_q <= '0;
                        nack_q  <= 1'b0;
                        err_q   <= 1'b0;
                        step_q  <= enabled_q ? STEP_BUS_DPR : STEP_CSR;
                    end
                end
                S_WB_WRITE: begin
                    if (port_done) begin
                        if (step_q == STEP_CSR) enabled_q <= 1'b1;
                        if (!cmd_step)          step_q    <= step_nx;
                    end
                end
                S_WAIT_IRQ: begin
                    if (!irq_i && timeout) err_q <= 1'b1;
                end
                S_WB_READ: begin
                    if (port_done) begin
                        if (step_q == STEP_RDATA_RD) begin
                            rdata_q <= port_rdata;
                            step_q  <= STEP_STOP_CMD;
                        end else if (step_q == STEP_STOP_CMD) begin
                            if (rd_fail) err_q <= 1'b1;
                        end else begin
                            st_nak_q  <= port_rdata[CMDR_NAK_BIT];
                            st_fail_q <= rd_fail;
                        end
                    end
                end
                S_EVAL: begin
                    if (st_fail_q) begin
                        err_q <= 1'b1;
                    end else if (st_nak_q && data_step) begin
                        nack_q <= 1'b1;
                        step_q <= STEP_STOP_CMD;
                    end else begin
                        step_q <= step_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Irq wait counter; cleared whenever not waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (state_q == S_WAIT_IRQ && !irq_i && !timeout)
            cnt_q <= cnt_q + CNT_W'(1);
        else
            cnt_q <= '0;
    end

    i2c_wb_master_port #(
        .WB_ADDR_WIDTH (WB_ADDR_WIDTH),
        .WB_DATA_WIDTH (WB_DATA_WIDTH)
    ) u_port (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (port_start),
        .we_i     (port_we),
        .adr_i    (port_adr),
        .dat_i    (port_dat),
        .done_o   (port_done),
        .rdata_o  (port_rdata),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

endmodule

// File: tb/tb_i2c_wb_cmd_sequencer.sv
// Directed bench for i2c_wb_cmd_sequencer with a small IICMB slave model.
// Logs every Wishbone access and compares against hand-written sequences.
module tb_i2c_wb_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic       req_op = 1'b0;
    logic [7:0] req_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       rsp_err;
    logic       wb_cyc;
    logic       wb_stb;
    logic       wb_we;
    logic [1:0] wb_adr;
    logic [7:0] wb_dat;
    logic [7:0] wb_dat_i = '0;
    logic       wb_ack = 1'b0;
    logic       irq = 1'b0;

    int checks = 0;
    int errors = 0;

    // slave model state
    logic [10:0] wlog [0:255];
    int          nlog = 0;
    int          cyc_n = 0;
    int          irq_timer = 0;
    int          irq_delay = 3;
    bit          irq_en = 1'b1;
    bit          bad_arm = 1'b0;
    logic [7:0]  bad_cmd = 8'h00;
    logic [7:0]  bad_status = 8'h00;
    logic [7:0]  last_cmd = 8'h00;
    int          last_ack_cyc = 0;
    int          rsp_cyc = 0;
    logic [10:0] expq [$];

    i2c_wb_cmd_sequencer #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_bus_i   (req_bus),
        .req_addr_i  (req_addr),
        .req_op_i    (req_op),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_nack_o  (rsp_nack),
        .rsp_err_o   (rsp_err),
        .wb_cyc_o    (wb_cyc),
        .wb_stb_o    (wb_stb),
        .wb_we_o     (wb_we),
        .wb_adr_o    (wb_adr),
        .wb_dat_o    (wb_dat),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack),
        .irq_i       (irq)
    );

    always #5 clk = ~clk;

    // IICMB slave: registered ack, irq after CMDR write, status on CMDR read
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rst) begin
            wb_ack    <= 1'b0;
            irq       <= 1'b0;
            irq_timer <= 0;
        end else begin
            wb_ack <= 1'b0;
            if (irq_timer > 0) begin
                irq_timer <= irq_timer - 1;
                if (irq_timer == 1) irq <= 1'b1;
            end
            if (wb_cyc && wb_stb && !wb_ack) begin
                wb_ack <= 1'b1;
                if (nlog < 256)
                    wlog[nlog] <= {wb_we, wb_adr, wb_we ? wb_dat : 8'h00};
                nlog <= nlog + 1;
                wb_dat_i <= 8'h00;
                if (wb_we && wb_adr == 2'd2) begin
                    last_cmd <= wb_dat;
                    if (irq_en) irq_timer <= irq_delay;
                end
                if (!wb_we && wb_adr == 2'd2) begin
                    irq <= 1'b0;
                    wb_dat_i <= (bad_arm && last_cmd == bad_cmd)
                                ? bad_status : 8'h80;
                end else if (!wb_we && wb_adr == 2'd1) begin
                    wb_dat_i <= 8'h3C;
                end
            end
        end
    end

    // cycle index of the most recent acknowledged access
    always @(negedge clk) begin
        if (wb_cyc && wb_ack) last_ack_cyc = cyc_n;
    end

    function automatic logic [10:0] enc(input logic we, input logic [1:0] a,
                                        input logic [7:0] d);
        return {we, a, d};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        expq.push_back(enc(1'b1, a, d));
    endtask

    task automatic rd(input logic [1:0] a);
        expq.push_back(enc(1'b0, a, 8'h00));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int base);
        chk({tag, "_count"}, nlog - base, expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_acc%0d", tag, i), wlog[(base + i) % 256], expq[i]);
        expq.delete();
    endtask

    task automatic send_req(input logic [3:0] b, input logic [6:0] a,
                            input logic op, input logic [7:0] d);
        bit got;
        got = 1'b0;
        req_bus = b;
        req_addr = a;
        req_op = op;
        req_data = d;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) got = 1'b1;
            @(negedge clk);
            if (got) break;
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_req not accepted within 50 cycles");
        end
    endtask

    task automatic wait_rsp(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                rsp_cyc = cyc_n;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_rsp no response within %0d cycles", budget);
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_dropped"}, rsp_valid, 1'b0);
        chk({tag, "_ready_back"}, req_ready, 1'b1);
    endtask

    initial begin
        int base;
        bit hit;

        // reset
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_outs", {rsp_valid, rsp_nack, rsp_err, rsp_data,
                         wb_cyc, wb_stb, wb_we, wb_adr, wb_dat}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1'b1);

        // 1: first WRITE, enable sequence included
        base = nlog;
        send_req(4'h1, 7'h22, 1'b0, 8'hA5);
        chk("t1_ready_drop", req_ready, 1'b0);
        wait_rsp(2000);
        chk("t1_nack", rsp_nack, 1'b0);
        chk("t1_err", rsp_err, 1'b0);
        chk("t1_data", rsp_data, 8'h00);
        chk("t1_lat", rsp_cyc - last_ack_cyc, 1);
        wr(0, 8'hC0); wr(1, 8'h01); wr(2, 8'h06); rd(2);
        wr(2, 8'h04); rd(2);
        wr(1, 8'h44); wr(2, 8'h01); rd(2);
        wr(1, 8'hA5); wr(2, 8'h01); rd(2);
        wr(2, 8'h05); rd(2);
        chk_seq("t1", base);
        handshake("t1");

        // 2: READ, already enabled
        base = nlog;
        send_req(4'h1, 7'h22, 1'b1, 8'hFF);
        wait_rsp(2000);
        chk("t2_nack", rsp_nack, 1'b0);
        chk("t2_err", rsp_err, 1'b0);
        chk("t2_data", rsp_data, 8'h3C);
        wr(1, 8'h01); wr(2, 8'h06); rd(2);
        wr(2, 8'h04); rd(2);
        wr(1, 8'h45); wr(2, 8'h01); rd(2);
        wr(2, 8'h03); rd(2); rd(1);
        wr(2, 8'h05); rd(2);
        chk_seq("t2", base);
        handshake("t2");

        // 3: address NAK -> STOP then nack response
        bad_arm = 1'b1;
        bad_cmd = 8'h01;
        bad_status = 8'hC0;
        base = nlog;
        send_req(4'h2, 7'h22, 1'b0, 8'h11);
        wait_rsp(2000);
        chk("t3_nack", rsp_nack, 1'b1);
        chk("t3_err", rsp_err, 1'b0);
        chk("t3_data", rsp_data, 8'h00);
        wr(1, 8'h02); wr(2, 8'h06); rd(2);
        wr(2, 8'h04); rd(2);
        wr(1, 8'h44); wr(2, 8'h01); rd(2);
        wr(2, 8'h05); rd(2);
        chk_seq("t3", base);
        handshake("t3");

        // 4: arbitration lost after START -> no STOP, err response
        bad_cmd = 8'h04;
        bad_status = 8'hA0;
        base = nlog;
        send_req(4'h1, 7'h22, 1'b1, 8'h00);
        wait_rsp(2000);
        chk("t4_nack", rsp_nack, 1'b0);
        chk("t4_err", rsp_err, 1'b1);
        chk("t4_data", rsp_data, 8'h00);
        handshake("t4");
        repeat (5) @(negedge clk);
        chk("t4_idle_cyc", wb_cyc, 1'b0);
        wr(1, 8'h01); wr(2, 8'h06); rd(2);
        wr(2, 8'h04); rd(2);
        chk_seq("t4", base);
        bad_arm = 1'b0;

        // 5: irq never arrives -> timeout after 16 waiting cycles
        irq_en = 1'b0;
        base = nlog;
        send_req(4'h1, 7'h22, 1'b0, 8'h5A);
        wait_rsp(2000);
        chk("t5_err", rsp_err, 1'b1);
        chk("t5_nack", rsp_nack, 1'b0);
        chk("t5_cyc", wb_cyc, 1'b0);
        chk("t5_lat", rsp_cyc - last_ack_cyc, 17);
        wr(1, 8'h01); wr(2, 8'h06);
        chk_seq("t5", base);
        handshake("t5");
        irq_en = 1'b1;

        // 6: reset during WAIT_IRQ, then enable is re-issued
        irq_delay = 12;
        base = nlog;
        send_req(4'h3, 7'h10, 1'b0, 8'h77);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (nlog - base == 2 && !wb_cyc) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t6_reached_wait", hit, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_outs", {req_ready, rsp_valid, rsp_nack, rsp_err,
                            rsp_data, wb_cyc, wb_stb, wb_we, wb_adr,
                            wb_dat}, 0);
        rst = 1'b0;
        irq_delay = 3;
        base = nlog;
        repeat (3) @(negedge clk);
        chk("t6_quiet", nlog - base, 0);
        chk("t6_ready", req_ready, 1'b1);
        send_req(4'h1, 7'h22, 1'b0, 8'hA5);
        wait_rsp(2000);
        chk("t6_err", rsp_err, 1'b0);
        chk("t6_first_csr", wlog[base % 256], enc(1'b1, 2'd0, 8'hC0));
        chk("t6_count", nlog - base, 14);
        handshake("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
